// File: rtl/or_unit_8bit.sv
// or_unit_8bit: bitwise OR for the single-cycle ALU, plus a
// registered result/flag copy for pipelined or debug consumers.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   A, B      signed operands
//   C         combinational A | B, valid at all times
//   in_valid  capture strobe for the registered path
//   c_reg     captured A | B
//   zero_reg  captured result == 0
//   neg_reg   captured result sign bit
//   out_valid one-cycle strobe following each capture
module or_unit_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    output logic signed [WIDTH-1:0] C,
    input  logic                    in_valid,
    output logic signed [WIDTH-1:0] c_reg,
    output logic                    zero_reg,
    output logic                    neg_reg,
    output logic                    out_valid
);

    logic [WIDTH-1:0] res;

    // Purely bitwise; the signed typing only affects display.
    assign res = A | B;
    assign C   = res;

    // Flags come from the value being captured, so they
    // always describe c_reg, never the live inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_reg     <= '0;
            zero_reg  <= 1'b1;
            neg_reg   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c_reg    <= res;
                zero_reg <= (res == '0);
                neg_reg  <= res[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_or_unit_8bit.sv
// tb_or_unit_8bit: self-checking bench for or_unit_8bit with a
// queue-based scoreboard for the registered path.
module tb_or_unit_8bit;

    typedef struct packed {
        logic [7:0] c;
        logic       z;
        logic       n;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic signed [7:0] A;
    logic signed [7:0] B;
    logic signed [7:0] C;
    logic              in_valid;
    logic signed [7:0] c_reg;
    logic              zero_reg;
    logic              neg_reg;
    logic              out_valid;

    exp_t       sb[$];
    int         checks;
    int         fails;
    logic [7:0] last_c;
    logic       last_z;
    logic       last_n;

    or_unit_8bit #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .C        (C),
        .in_valid (in_valid),
        .c_reg    (c_reg),
        .zero_reg (zero_reg),
        .neg_reg  (neg_reg),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(
        input logic [7:0] a,
        input logic [7:0] b
    );
        exp_t e;
        for (int i = 0; i < 8; i++)
            e.c[i] = (a[i] == 1'b1) || (b[i] == 1'b1);
        e.z = (e.c == 8'h00);
        e.n = e.c[7];
        return e;
    endfunction

    // Drive one cycle of stimulus at the falling edge and record
    // the expected capture when the strobe is set.
    task automatic drive(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic       v
    );
        @(negedge clk);
        A = a;
        B = b;
        in_valid = v;
        if (v) sb.push_back(model(a, b));
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b1;
        A = 8'h12;
        B = 8'h40;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({c_reg, zero_reg, neg_reg, out_valid} !== 11'b0000_0000_1_0_0) begin
            fails++;
            $display("FAIL reset_regs: got c=%h z=%b n=%b v=%b want c=00 z=1 n=0 v=0",
                     c_reg, zero_reg, neg_reg, out_valid);
        end
        checks++;
        if (C !== 8'h52) begin
            fails++;
            $display("FAIL reset_comb: got %h want 52", C);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        last_c = 8'h00;
        last_z = 1'b1;
        last_n = 1'b0;
    endtask

    task automatic test_comb;
        A = 8'd1;
        B = 8'd0;
        #1;
        checks++;
        if (C !== 8'd1) begin
            fails++;
            $display("FAIL comb_1_0: got %h want 01", C);
        end
        A = 8'b11010100;
        B = 8'd10;
        #5;
        checks++;
        if (C !== 8'hDE) begin
            fails++;
            $display("FAIL comb_neg: got %h want de", C);
        end
        A = 8'd15;
        B = 8'd11;
        #1;
        checks++;
        if (C !== 8'd15) begin
            fails++;
            $display("FAIL comb_15_11: got %h want 0f", C);
        end
        A = 8'hFF;
        B = 8'($urandom);
        #1;
        checks++;
        if (C !== 8'hFF) begin
            fails++;
            $display("FAIL comb_sat: got %h want ff (B=%h)", C, B);
        end
        A = 8'h55;
        B = 8'hAA;
        #1;
        checks++;
        if (C !== 8'hFF) begin
            fails++;
            $display("FAIL comb_55_aa: got %h want ff", C);
        end
    endtask

    task automatic test_registered;
        exp_t e;
        drive(8'hD4, 8'h0A, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL reg_valid: got %b want 1", out_valid);
        end
        checks++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL reg_sb_empty: got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            if ({c_reg, zero_reg, neg_reg} !== {e.c, e.z, e.n}) begin
                fails++;
                $display("FAIL reg_capture: got c=%h z=%b n=%b want c=%h z=%b n=%b",
                         c_reg, zero_reg, neg_reg, e.c, e.z, e.n);
            end
            {last_c, last_z, last_n} = {e.c, e.z, e.n};
        end
        checks++;
        if ({c_reg, zero_reg, neg_reg} !== {8'hDE, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reg_de: got c=%h z=%b n=%b want c=de z=0 n=1",
                     c_reg, zero_reg, neg_reg);
        end
        drive(8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || c_reg !== 8'hDE) begin
            fails++;
            $display("FAIL reg_hold: got v=%b c=%h want v=0 c=de",
                     out_valid, c_reg);
        end
    endtask

    task automatic test_zero_flag;
        exp_t e;
        logic [7:0] ta [2];
        logic [7:0] tb [2];
        ta[0] = 8'h00; tb[0] = 8'h00;
        ta[1] = 8'h55; tb[1] = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            drive(ta[i], tb[i], 1'b1);
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL zero_valid: got v=%b q=%0d want v=1 q>0",
                         out_valid, sb.size());
            end else begin
                e = sb.pop_front();
                if ({c_reg, zero_reg, neg_reg} !== {e.c, e.z, e.n}) begin
                    fails++;
                    $display("FAIL zero_cap%0d: got c=%h z=%b n=%b want c=%h z=%b n=%b",
                             i, c_reg, zero_reg, neg_reg, e.c, e.z, e.n);
                end
                {last_c, last_z, last_n} = {e.c, e.z, e.n};
            end
        end
        checks++;
        if ({c_reg, zero_reg, neg_reg} !== {8'hFF, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL sat_flags: got c=%h z=%b n=%b want c=ff z=0 n=1",
                     c_reg, zero_reg, neg_reg);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic [7:0] want [3];
        ta[0] = 8'h01; tb[0] = 8'h00; want[0] = 8'h01;
        ta[1] = 8'h0F; tb[1] = 8'h0B; want[1] = 8'h0F;
        ta[2] = 8'h80; tb[2] = 8'h01; want[2] = 8'h81;
        for (int i = 0; i < 3; i++) begin
            drive(ta[i], tb[i], 1'b1);
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                fails++;
                $display("FAIL b2b_valid%0d: got v=%b want 1", i, out_valid);
            end else begin
                e = sb.pop_front();
                if ({c_reg, zero_reg, neg_reg} !== {e.c, e.z, e.n}
                    || c_reg !== want[i]
                    || neg_reg !== (i == 2)) begin
                    fails++;
                    $display("FAIL b2b_cap%0d: got c=%h n=%b want c=%h n=%b",
                             i, c_reg, neg_reg, want[i], (i == 2));
                end
                {last_c, last_z, last_n} = {e.c, e.z, e.n};
            end
        end
        drive(8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_random;
        exp_t e;
        logic v;
        for (int i = 0; i < 24; i++) begin
            v = 1'($urandom_range(0, 1));
            drive(8'($urandom), 8'($urandom), v);
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== v) begin
                fails++;
                $display("FAIL rnd_valid%0d: got %b want %b", i, out_valid, v);
            end else if (v) begin
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL rnd_sb_empty%0d: got 0 want 1", i);
                end else begin
                    e = sb.pop_front();
                    if ({c_reg, zero_reg, neg_reg} !== {e.c, e.z, e.n}) begin
                        fails++;
                        $display("FAIL rnd_cap%0d: got c=%h z=%b n=%b want c=%h z=%b n=%b",
                                 i, c_reg, zero_reg, neg_reg, e.c, e.z, e.n);
                    end
                    {last_c, last_z, last_n} = {e.c, e.z, e.n};
                end
            end else if ({c_reg, zero_reg, neg_reg} !== {last_c, last_z, last_n}) begin
                fails++;
                $display("FAIL rnd_hold%0d: got c=%h z=%b n=%b want c=%h z=%b n=%b",
                         i, c_reg, zero_reg, neg_reg, last_c, last_z, last_n);
            end
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        drive(8'h80, 8'h01, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            fails++;
            $display("FAIL arst_pre: got v=%b want 1", out_valid);
        end else begin
            e = sb.pop_front();
            if (c_reg !== e.c) begin
                fails++;
                $display("FAIL arst_pre_c: got %h want %h", c_reg, e.c);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({c_reg, zero_reg, neg_reg, out_valid} !== 11'b0000_0000_1_0_0) begin
            fails++;
            $display("FAIL arst_regs: got c=%h z=%b n=%b v=%b want c=00 z=1 n=0 v=0",
                     c_reg, zero_reg, neg_reg, out_valid);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        drive(8'h22, 8'h11, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL arst_first: got v=%b want 1", out_valid);
        end else begin
            e = sb.pop_front();
            if ({c_reg, zero_reg, neg_reg} !== {e.c, e.z, e.n}) begin
                fails++;
                $display("FAIL arst_first_c: got c=%h z=%b n=%b want c=%h z=%b n=%b",
                         c_reg, zero_reg, neg_reg, e.c, e.z, e.n);
            end
        end
        drive(8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        fails = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        A = '0;
        B = '0;
        test_reset();
        test_comb();
        test_registered();
        test_zero_flag();
        test_back_to_back();
        test_random();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/or_unit_8bit.md
Name: or_unit_8bit

Overview:
- 8-bit bitwise OR unit for the ALU of the 8-bit single-cycle processor.
- Produces combinational result C = A | B with zero latency, as required by the single-cycle datapath.
- Also provides a registered copy of the result and status flags (zero, negative) with a valid strobe, for pipelined or debug consumers.
- Operands and result are treated as signed two's-complement for display and flags only; the OR itself is purely bitwise.

Parameters:
- WIDTH, 8, operand/result width in bits; all widths below are WIDTH (8 by default).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- A  input  8  operand A (signed)
- B  input  8  operand B (signed)
- C  output  8  combinational result A | B (signed)
- in_valid  input  1  capture strobe for the registered path
- c_reg  output  8  registered result
- zero_reg  output  1  registered flag: captured result == 0
- neg_reg  output  1  registered flag: captured result bit 7
- out_valid  output  1  high for one cycle after a capture

Behaviour:
- C = A | B bitwise, per bit, at all times, including during reset. It has no clock dependence and settles within the same delta/cycle.
- No carry, no overflow, and no sign extension. Bit i of C depends only on bits i of A and B.
- Registered path on rising clk:
  - If in_valid = 1: c_reg <= A | B, zero_reg <= (A | B) == 0, neg_reg <= (A | B)[7], out_valid <= 1.
  - If in_valid = 0: c_reg, zero_reg and neg_reg hold their values; out_valid <= 0.
- Latency of the registered path: 1 cycle. Back-to-back in_valid captures every cycle, and out_valid stays high continuously.
- Reset (rst_n = 0, asynchronous, immediate regardless of clk):
  - c_reg = 0, zero_reg = 1, neg_reg = 0, out_valid = 0.
  - Reset asserted mid-capture overrides the capture.
  - Deassertion is sampled normally. The first capture is possible on the first rising edge with rst_n = 1.
- Flags are derived from the captured value only, never from live inputs.
- X/Z on inputs: no special handling required.

Test Plan:
- Reset: assert rst_n = 0 with in_valid = 1 and clock running -> c_reg = 0, zero_reg = 1, neg_reg = 0, out_valid = 0; C still equals A | B.
- Combinational: A = 1, B = 0 -> C = 1 immediately. Then A = 8'b11010100 (-44), B = 10 -> C = 8'b11011110 (0xDE, -34) within 5 time units. Then A = 15, B = 11 -> C = 15.
- Registered: in_valid = 1 with A = 0xD4, B = 0x0A for one cycle -> next cycle c_reg = 0xDE, neg_reg = 1, zero_reg = 0, out_valid = 1. The following cycle, with in_valid = 0 -> out_valid = 0 and c_reg holds 0xDE.
- Zero flag: A = 0, B = 0 captured -> c_reg = 0, zero_reg = 1, neg_reg = 0. Identity and saturation checks: A = 0xFF, B = x -> C = 0xFF; A = 0x55, B = 0xAA -> C = 0xFF, neg_reg = 1 after capture.
- Back-to-back: in_valid held high over 3 cycles with (1,0), (15,11), (0x80,0x01) -> c_reg sequence 1, 15, 0x81; out_valid continuously 1; neg_reg = 1 only for 0x81.
- Async reset mid-stream: drop rst_n between clock edges while out_valid = 1 -> all registered outputs go to reset values before the next edge.
